argmax_classifier: RTL

//  Consumes the packed 10-class score vector from the vector-matrix product stage and picks the predicted digit.
//  - Scans the scores serially, one class per cycle.
//  - Reports the winning class index, its score, and the margin over the runner-up (a confidence measure).
//  - Sits directly downstream of the product stage; valid/ready handshake on both sides.

---
 rtl/argmax_classifier.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/argmax_classifier.sv
// -----------------------------------------------------------------------------
// argmax_classifier
//   Picks the predicted digit from a packed vector of signed class scores.
//   The vector is captured in one cycle, then scanned one class per cycle,
//   tracking the best and second-best scores. The winner index, its score and
//   the margin over the runner-up are presented with a valid/ready handshake.
//
// Ports
//   clk          in   rising-edge clock
//   GlobalReset  in   asynchronous, active-high reset
//   Scores       in   NUM_CLASSES*SCORE_W, class k at Scores[k*SCORE_W +: SCORE_W]
//   in_valid     in   Scores valid this cycle
//   in_ready     out  block can accept a vector (high only in IDLE)
//   out_valid    out  result fields valid, held until accepted
//   out_ready    in   consumer accepts the result
//   digit        out  index of the maximum score
//   max_score    out  maximum score (signed Q8.18)
//   margin       out  max_score minus runner-up (unsigned, >= 0)
// -----------------------------------------------------------------------------
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 26,
  parameter int IDX_W       = 4
) (
  input  logic                           clk,
  input  logic                           GlobalReset,
  input  logic [NUM_CLASSES*SCORE_W-1:0] Scores,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               digit,
  output logic [SCORE_W-1:0]             max_score,
  output logic [SCORE_W-1:0]             margin
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Most negative representable score: the starting value for second-best,
  // so any real score displaces it and the margin stays exact.
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(NUM_CLASSES-1);

  state_t state_r;
  state_t state_s;

  logic signed [SCORE_W-1:0] score_mem_r [NUM_CLASSES];
  logic        [IDX_W-1:0]   cnt_r;
  logic signed [SCORE_W-1:0] best_r;
  logic signed [SCORE_W-1:0] second_r;
  logic        [IDX_W-1:0]   idx_r;

  logic                      in_ready_r;
  logic                      out_valid_r;
  logic        [IDX_W-1:0]   digit_r;
  logic        [SCORE_W-1:0] max_score_r;
  logic        [SCORE_W-1:0] margin_r;

  logic signed [SCORE_W-1:0] cur_s;
  logic signed [SCORE_W-1:0] best_s;
  logic signed [SCORE_W-1:0] second_s;
  logic        [IDX_W-1:0]   idx_s;
  logic        [SCORE_W-1:0] margin_s;
  logic                      last_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign digit     = digit_r;
  assign max_score = max_score_r;
  assign margin    = margin_r;

  // One comparison step for the class currently addressed by the scan counter.
  always_comb begin
    cur_s    = score_mem_r[cnt_r];
    best_s   = best_r;
    second_s = second_r;
    idx_s    = idx_r;
    last_s   = (cnt_r == LAST_IDX);
    // Strict compares: on a tie the lower index keeps the lead and the equal
    // score becomes the runner-up, giving a zero margin.
    if (cur_s > best_r) begin
      second_s = best_r;
      best_s   = cur_s;
      idx_s    = cnt_r;
    end else if (cur_s > second_r) begin
      second_s = cur_s;
    end else begin
      second_s = second_r;
    end
    // best >= second always, so the difference fits SCORE_W bits unsigned.
    margin_s = SCORE_W'(best_s - second_s);
  end

  // Next-state logic for the IDLE -> SCAN -> HOLD -> IDLE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (last_s) begin
          state_s = HOLD;
        end else begin
          state_s = SCAN;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture, scan datapath and registered result/handshake outputs.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        score_mem_r[k] <= {SCORE_W{1'b0}};
      end
      cnt_r       <= {IDX_W{1'b0}};
      best_r      <= {SCORE_W{1'b0}};
      second_r    <= {SCORE_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      digit_r     <= {IDX_W{1'b0}};
      max_score_r <= {SCORE_W{1'b0}};
      margin_r    <= {SCORE_W{1'b0}};
    end else begin
      in_ready_r <= (state_s == IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
              score_mem_r[k] <= Scores[k*SCORE_W +: SCORE_W];
            end
            // Class 0 seeds the best; the scan starts at class 1.
            best_r   <= Scores[SCORE_W-1:0];
            second_r <= SCORE_MIN;
            idx_r    <= {IDX_W{1'b0}};
            cnt_r    <= IDX_W'(1);
          end
        end
        SCAN: begin
          best_r   <= best_s;
          second_r <= second_s;
          idx_r    <= idx_s;
          cnt_r    <= cnt_r + IDX_W'(1);
          // Publish the final step's result directly so out_valid rises on
          // the same edge the last class is compared.
          if (last_s) begin
            out_valid_r <= 1'b1;
            digit_r     <= idx_s;
            max_score_r <= best_s;
            margin_r    <= margin_s;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
